// File: rtl/fetch_exec_sequencer.sv
// rtl/fetch_exec_sequencer.sv - fetch/execute microsequencer with return-address stack
//
// Purpose: fetches an instruction word from memory at pc, then steps a one-hot
// microstep counter while the external decoder drives control lines. The
// decoder can halt, skip, jump, call or return. Calls and returns use a small
// return-address stack; an overflow or underflow halts the sequencer with a
// sticky fault that only reset clears.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   mem_req, mem_addr     fetch request (high in FETCH) and fetch address (= pc)
//   mem_rdata, mem_ack    fetched word and its completion strobe
//   inst_condition, end_inst, jmp_inst, call_inst, ret_inst, hlt_inst
//                         decoder controls, looked at only in EXEC
//   jmp_address           jump / call target
//   resume                leave HALT (ignored while stack_fault is set)
//   ir, step, pc, state   instruction register, one-hot microstep, pc, FSM state
//   sp, stack_fault       occupied stack entries, sticky stack fault
module fetch_exec_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int INST_W      = 32,
  parameter int STEPS       = 16,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              inst_condition,
  input  logic              end_inst,
  input  logic              jmp_inst,
  input  logic              call_inst,
  input  logic              ret_inst,
  input  logic              hlt_inst,
  input  logic [ADDR_W-1:0] jmp_address,
  input  logic              resume,
  output logic [INST_W-1:0] ir,
  output logic [STEPS-1:0]  step,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        state,
  output logic [SP_W-1:0]   sp,
  output logic              stack_fault
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam int              IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0]   ir_q;
  logic [STEPS-1:0]    step_q, step_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic                fault_q;
  logic [ADDR_W-1:0]   stack_mem [STACK_DEPTH];

  logic [ADDR_W-1:0]   pc_inc;
  logic [IDX_W-1:0]    push_idx;
  logic [IDX_W-1:0]    top_idx;
  logic                stack_full;
  logic                stack_empty;
  logic                stack_overflow;
  logic                stack_underflow;
  logic                load_ir;
  logic                push_en;
  logic                set_fault;

  assign pc_inc      = pc_q + ADDR_W'(1);
  assign stack_full  = (sp_q == SP_FULL);
  assign stack_empty = (sp_q == '0);
  // Push goes into slot sp, the top of stack lives in slot sp-1.
  assign push_idx    = IDX_W'(sp_q);
  assign top_idx     = IDX_W'(sp_q - SP_W'(1));

  // Stack faults as seen by an end_inst, honouring jmp > call > ret priority.
  assign stack_overflow  = ~jmp_inst & call_inst & stack_full;
  assign stack_underflow = ~jmp_inst & ~call_inst & ret_inst & stack_empty;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (hlt_inst) begin
          state_d = ST_HALT;
        end else if (!inst_condition) begin
          state_d = ST_FETCH;
        end else if (end_inst) begin
          state_d = (stack_overflow || stack_underflow) ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        if (resume && !fault_q) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Output / datapath control logic
  always_comb begin
    pc_d      = pc_q;
    step_d    = step_q;
    sp_d      = sp_q;
    load_ir   = 1'b0;
    push_en   = 1'b0;
    set_fault = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          load_ir = 1'b1;
          step_d  = STEPS'(1);
        end
      end
      ST_EXEC: begin
        if (!hlt_inst) begin
          if (!inst_condition) begin
            pc_d = pc_inc;
          end else if (end_inst) begin
            if (jmp_inst) begin
              pc_d = jmp_address;
            end else if (call_inst) begin
              if (stack_full) begin
                set_fault = 1'b1;
              end else begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                pc_d    = jmp_address;
              end
            end else if (ret_inst) begin
              if (stack_empty) begin
                set_fault = 1'b1;
              end else begin
                pc_d = stack_mem[top_idx];
                sp_d = sp_q - SP_W'(1);
              end
            end else begin
              pc_d = pc_inc;
            end
          end else begin
            step_d = {step_q[STEPS-2:0], step_q[STEPS-1]};
          end
        end
      end
      ST_HALT: begin
        if (resume && !fault_q) pc_d = pc_inc;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      ir_q    <= '0;
      step_q  <= '0;
      sp_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      step_q <= step_d;
      sp_q   <= sp_d;
      if (load_ir)   ir_q    <= mem_rdata;
      if (set_fault) fault_q <= 1'b1;
    end
  end

  // Stack storage is not reset; sp alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[push_idx] <= pc_inc;
  end

  assign mem_req     = (state_q == ST_FETCH);
  assign mem_addr    = pc_q;
  assign ir          = ir_q;
  assign step        = step_q;
  assign pc          = pc_q;
  assign state       = state_q;
  assign sp          = sp_q;
  assign stack_fault = fault_q;

endmodule

// File: doc/fetch_exec_sequencer.md
FETCH_EXEC_SEQUENCER -- requirements
Module: fetch_exec_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program-counter/address width.
REQ-002 SHALL have parameter INST_W, default 32, instruction width.
REQ-003 SHALL have parameter STEPS, default 16 (range 2..32), one-hot microstep width.
REQ-004 SHALL have parameter STACK_DEPTH, default 4 (>=1), return-address stack entries.
REQ-005 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port mem_req  output  1  fetch request, equals (state==FETCH).
REQ-008 SHALL have port mem_addr  output  ADDR_W  fetch address, equals pc.
REQ-009 SHALL have port mem_rdata  input  INST_W  fetched word, valid when mem_ack=1.
REQ-010 SHALL have port mem_ack  input  1  fetch completion, honoured only in FETCH.
REQ-011 SHALL have ports inst_condition, end_inst, jmp_inst, call_inst, ret_inst, hlt_inst  input  1 each  decoder controls, sampled only in EXEC.
REQ-012 SHALL have port jmp_address  input  ADDR_W  jump/call target.
REQ-013 SHALL have port resume  input  1  leave HALT.
REQ-014 SHALL have port ir  output  INST_W  instruction register.
REQ-015 SHALL have port step  output  STEPS  one-hot microstep counter.
REQ-016 SHALL have port pc  output  ADDR_W  program counter.
REQ-017 SHALL have port state  output  2  FETCH=0, EXEC=1, HALT=2; 3 unused.
REQ-018 SHALL have port sp  output  clog2(STACK_DEPTH+1)  occupied stack entries.
REQ-019 SHALL have port stack_fault  output  1  sticky stack overflow/underflow flag.

Function
REQ-020 FETCH: while mem_ack=0 SHALL hold all registers; on mem_ack=1 SHALL load ir<=mem_rdata, step<=bit0, state<=EXEC (mem_req low the next cycle).
REQ-021 EXEC priority SHALL be hlt_inst > ~inst_condition > end_inst > step advance.
REQ-022 EXEC, hlt_inst=1: state<=HALT; pc, ir, step, stack unchanged.
REQ-023 EXEC, inst_condition=0: pc<=pc+1, state<=FETCH.
REQ-024 EXEC, end_inst=1: action by priority jmp_inst > call_inst > ret_inst > none; state<=FETCH unless faulting.
REQ-025 jmp: pc<=jmp_address.
REQ-026 call, sp<STACK_DEPTH: push pc+1 (mod 2^ADDR_W), sp<=sp+1, pc<=jmp_address.
REQ-027 ret, sp>0: pc<=top entry, sp<=sp-1.
REQ-028 none: pc<=pc+1.
REQ-029 call with sp==STACK_DEPTH or ret with sp==0: stack_fault<=1, state<=HALT, pc/sp unchanged.
REQ-030 EXEC, no terminating condition: step SHALL rotate left one bit; from bit STEPS-1 SHALL wrap to bit0.
REQ-031 HALT: step, pc, ir, stack frozen; resume=1 with stack_fault=0 SHALL give pc<=pc+1, state<=FETCH; resume ignored while stack_fault=1.
REQ-032 pc arithmetic SHALL be modulo 2^ADDR_W (all-ones +1 -> 0).
REQ-033 step SHALL be all-zero outside EXEC-entry history only after reset; otherwise exactly one bit set.
REQ-034 Decoder inputs in FETCH/HALT and mem_ack outside FETCH SHALL have no effect.

Reset
REQ-035 reset=1 SHALL immediately force pc=0, ir=0, step=0, state=FETCH, sp=0, stack_fault=0, independent of clk.
REQ-036 Reset mid-fetch or mid-execute SHALL abandon the operation; first fetch after release uses address 0.
REQ-037 Stack contents need not be cleared; only sp defines validity.

Verification
REQ-038 Reset release, mem_ack delayed 3 cycles, mem_rdata=0xDEADBEEF -> mem_req high 4 cycles, ir=0xDEADBEEF, state=EXEC, step=0x0001.
REQ-039 EXEC at pc=0x05, end_inst=0 for 17 cycles -> step walks 0x0002..0x8000 then 0x0001, 0x0002.
REQ-040 pc=0x10, call to 0x40 with end_inst; then at 0x40 ret -> pc=0x40, sp=1, then pc=0x11, sp=0.
REQ-041 Five nested calls with STACK_DEPTH=4 -> fifth sets stack_fault=1, state=HALT, sp=4; resume ignored.
REQ-042 pc=0xFF, inst_condition=0 -> pc=0x00, state=FETCH; hlt_inst with inst_condition=0 -> HALT, pc unchanged; resume -> pc+1, FETCH.
REQ-043 Assert reset during EXEC with sp=2 -> all outputs reset values same cycle, sp=0.
